// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32 datapath.
// Latency: none, this is wiring only.
// Backpressure: none; the datapath consumes the controls every cycle.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       IllegalInstr;
  logic       InstrDone;

  // Controller side: reads instruction fields and Zero, drives the controls.
  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, IllegalInstr, InstrDone
  );

  // Datapath side: supplies instruction fields and Zero, consumes the controls.
  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, IllegalInstr, InstrDone
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control unit: Moore FSM, ALU decoder and immediate-type decoder.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles; outputs are combinational from state.
// Backpressure: none; advances one state per clock, instruction fields are held by the IR.
module multicycle_controller (
  input  logic clk,
  input  logic rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state, state_nxt, state_dec;
  logic       op_legal;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic       adr_src, mem_write, ir_write, reg_write, illegal, done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  // While in reset the selects show the FETCH decode, whatever the state register holds.
  assign state_dec = rst_n ? state : S_FETCH;

  // State register with synchronous active-low reset back to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Supported-encoding check, only meaningful in DECODE.
  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_JAL: op_legal = 1'b1;
      OP_R, OP_I:           op_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                                       (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
      OP_BEQ:               op_legal = (bus.funct3 == 3'b000);
      default:              op_legal = 1'b0;
    endcase
  end

  // Next-state logic; unsupported encodings fall straight back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (!op_legal) state_nxt = S_FETCH;
        else begin
          case (bus.op)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_R:         state_nxt = S_EXECR;
            OP_I:         state_nxt = S_EXECI;
            OP_BEQ:       state_nxt = S_BEQ;
            OP_JAL:       state_nxt = S_JAL;
            default:      state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Per-state Moore outputs; don't-care selects are driven to 00.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    done       = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (state_dec)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = !op_legal;
        done      = !op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: op[5] separates R-type sub from I-type addi with Instr[30] set.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate-type decode straight from the opcode.
  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.PCWrite      = rst_n & ((branch & bus.Zero) | pc_update);
  assign bus.AdrSrc       = adr_src;
  assign bus.MemWrite     = rst_n & mem_write;
  assign bus.IRWrite      = rst_n & ir_write;
  assign bus.ResultSrc    = result_src;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.RegWrite     = rst_n & reg_write;
  assign bus.ImmSrc       = imm_src;
  assign bus.ALUControl   = alu_control;
  assign bus.IllegalInstr = rst_n & illegal;
  assign bus.InstrDone    = rst_n & done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] SYS = 7'b1110011;

  // Expected word: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
  //                 ALUSrcB, RegWrite, ImmSrc, ALUControl, IllegalInstr, InstrDone}
  typedef struct packed {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic [17:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic rw, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ill, input logic dn);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill, dn};
  endfunction

  function automatic logic [17:0] got();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl, bus.IllegalInstr, bus.InstrDone};
  endfunction

  // Hand-tabulated per-state expectations.
  function automatic logic [17:0] e_rst(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_fetch(input logic [1:0] imm);
    return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_dec(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_ill(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 3'b000, 1, 1);
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [17:0] e);
    vec_t v;
    v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  // Runs one instruction from FETCH until InstrDone and checks its cycle count.
  task automatic measure(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int exp_n, input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.InstrDone) seen = 1;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (!seen || n != exp_n) begin
      n_bad++;
      $display("FAIL latency_%s: got %0d cycles (done seen=%0d), want %0d", name, n, seen, exp_n);
    end
  endtask

  initial begin
    // Reset for two cycles with an R-type in the IR.
    add(0, RT, 3'b000, 0, 0, e_rst(2'b00));
    add(0, RT, 3'b000, 0, 0, e_rst(2'b00));
    // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
    add(1, LW, 3'b010, 0, 0, e_fetch(2'b00));
    add(1, LW, 3'b010, 0, 0, e_dec(2'b00));
    add(1, LW, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'b000, 0, 0));
    add(1, LW, 3'b010, 0, 0, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0));
    add(1, LW, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // sw: FETCH, DECODE, MEMADR, MEMWRITE
    add(1, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add(1, SW, 3'b010, 0, 0, e_dec(2'b01));
    add(1, SW, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b01, 3'b000, 0, 0));
    add(1, SW, 3'b010, 0, 0, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0, 1));
    // sub
    add(1, RT, 3'b000, 1, 0, e_fetch(2'b00));
    add(1, RT, 3'b000, 1, 0, e_dec(2'b00));
    add(1, RT, 3'b000, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 3'b001, 0, 0));
    add(1, RT, 3'b000, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // addi with Instr[30]=1 stays add
    add(1, IT, 3'b000, 1, 0, e_fetch(2'b00));
    add(1, IT, 3'b000, 1, 0, e_dec(2'b00));
    add(1, IT, 3'b000, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'b000, 0, 0));
    add(1, IT, 3'b000, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // slt (R)
    add(1, RT, 3'b010, 0, 0, e_fetch(2'b00));
    add(1, RT, 3'b010, 0, 0, e_dec(2'b00));
    add(1, RT, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 3'b101, 0, 0));
    add(1, RT, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // ori (I)
    add(1, IT, 3'b110, 0, 0, e_fetch(2'b00));
    add(1, IT, 3'b110, 0, 0, e_dec(2'b00));
    add(1, IT, 3'b110, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'b011, 0, 0));
    add(1, IT, 3'b110, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // and (R)
    add(1, RT, 3'b111, 0, 0, e_fetch(2'b00));
    add(1, RT, 3'b111, 0, 0, e_dec(2'b00));
    add(1, RT, 3'b111, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 3'b010, 0, 0));
    add(1, RT, 3'b111, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 1));
    // beq taken; Zero=1 in DECODE must not write the PC
    add(1, BQ, 3'b000, 0, 0, e_fetch(2'b10));
    add(1, BQ, 3'b000, 0, 1, e_dec(2'b10));
    add(1, BQ, 3'b000, 0, 1, pk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 3'b001, 0, 1));
    // beq not taken
    add(1, BQ, 3'b000, 0, 0, e_fetch(2'b10));
    add(1, BQ, 3'b000, 0, 0, e_dec(2'b10));
    add(1, BQ, 3'b000, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 3'b001, 0, 1));
    // jal
    add(1, JL, 3'b000, 0, 0, e_fetch(2'b11));
    add(1, JL, 3'b000, 0, 0, e_dec(2'b11));
    add(1, JL, 3'b000, 0, 0, pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b11, 3'b000, 0, 0));
    add(1, JL, 3'b000, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b11, 3'b000, 0, 1));
    // Illegal opcode
    add(1, SYS, 3'b000, 0, 0, e_fetch(2'b00));
    add(1, SYS, 3'b000, 0, 0, e_ill(2'b00));
    // beq with funct3 != 000 is illegal
    add(1, BQ, 3'b001, 0, 1, e_fetch(2'b10));
    add(1, BQ, 3'b001, 0, 1, e_ill(2'b10));
    // lw aborted by reset in MEMREAD
    add(1, LW, 3'b010, 0, 0, e_fetch(2'b00));
    add(1, LW, 3'b010, 0, 0, e_dec(2'b00));
    add(1, LW, 3'b010, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'b000, 0, 0));
    add(0, LW, 3'b010, 0, 0, e_rst(2'b00));
    // Next instruction (R-type funct3=001, illegal) starts from FETCH
    add(1, RT, 3'b001, 0, 0, e_fetch(2'b00));
    add(1, RT, 3'b001, 0, 0, e_ill(2'b00));

    foreach (vecs[i]) begin
      rst_n        = vecs[i].rst_n;
      bus.op       = vecs[i].op;
      bus.funct3   = vecs[i].f3;
      bus.funct7b5 = vecs[i].f7;
      bus.Zero     = vecs[i].zero;
      @(negedge clk);
      n_vec++;
      if (got() !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL vec[%0d] op=%b f3=%b: got %b, want %b", i, vecs[i].op, vecs[i].f3,
                 got(), vecs[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // Whole-instruction latencies measured from FETCH to InstrDone.
    rst_n = 1'b1;
    measure(LW,  3'b010, 0, 5, "lw");
    measure(SW,  3'b010, 0, 4, "sw");
    measure(RT,  3'b000, 0, 4, "add");
    measure(IT,  3'b111, 0, 4, "andi");
    measure(JL,  3'b000, 0, 4, "jal");
    measure(BQ,  3'b000, 0, 3, "beq");
    measure(SYS, 3'b000, 0, 2, "illegal");
    measure(IT,  3'b011, 0, 2, "illegal_i");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
